// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the access size encodings, the FSM state type and the byte-lane
// helper functions used by the lane aligner. Lane logic is fixed at 32 bits.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_WR,
    ST_DONE
  } lsu_state_e;

  // Half at an odd address, word not on a word boundary, or the illegal size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of word with the low bits of data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: r[{off, 3'b000} +: 8] = data[7:0];
      SZ_H: begin
        if (off[1]) r[31:16] = data[15:0];
        else        r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Combinational byte-lane aligner for the load/store unit.
// Ports:
//   rdata    - word returned by memory
//   wdata    - right-aligned store data
//   off      - byte offset within the word (address bits [1:0])
//   size     - access size encoding
//   uns      - zero-extend loads when set
//   load_ext - extracted and extended load value
//   merged   - rdata with the store lane replaced by wdata
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  assign load_ext = lane_extract(rdata, off, size, uns);
  assign merged   = lane_merge(rdata, wdata, off, size);

endmodule

// File: rtl/mem_lsu.sv
// MIPS MEM-stage load/store initiator.
// Converts pipeline memory ops into req/ack transactions on a word-addressed
// memory, doing read-modify-write for sub-word stores and lane extraction with
// extension for loads. stall_M holds the pipeline until the op completes.
// Ports:
//   Mem_Read_M/Mem_Write_M/Size_M/Unsigned_M/ALU_result_M/Write_Data_M - op from EX/MEM
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata - memory side
//   load_data_M, done_M, stall_M, misalign_M, bus_err_M - results back to pipeline
// Memory handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable
// from the cycle mem_req rises until the cycle mem_ack is sampled high; the
// transfer happens on that clock edge and mem_req drops (or moves on to the
// write phase of a read-modify-write) on the following cycle. mem_ack while
// no request is outstanding is ignored.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_Read_M,
  input  logic              Mem_Write_M,
  input  logic [1:0]        Size_M,
  input  logic              Unsigned_M,
  input  logic [ADDR_W-1:0] ALU_result_M,
  input  logic [DATA_W-1:0] Write_Data_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data_M,
  output logic              done_M,
  output logic              stall_M,
  output logic              misalign_M,
  output logic              bus_err_M
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic              op_valid;
  logic              op_mis;
  logic              in_req;
  logic              timeout_hit;

  assign op_valid = Mem_Read_M | Mem_Write_M;
  assign op_mis   = is_misaligned(Size_M, ALU_result_M[1:0]);
  assign in_req   = (state == ST_RD) || (state == ST_RMW_RD) ||
                    (state == ST_RMW_WR) || (state == ST_WR);

  lsu_lane_align u_align (
    .rdata    (mem_rdata),
    .wdata    (wdata_q),
    .off      (off_q),
    .size     (size_q),
    .uns      (uns_q),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    stall_M     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        // Misaligned ops are rejected here without stalling the pipeline.
        if (op_valid && !op_mis) begin
          stall_M = 1'b1;
          if (Mem_Write_M) next_state = (Size_M == SZ_W) ? ST_WR : ST_RMW_RD;
          else             next_state = ST_RD;
        end
      end
      ST_RD, ST_RMW_RD, ST_RMW_WR, ST_WR: begin
        stall_M = 1'b1;
        if (mem_ack) begin
          next_state = (state == ST_RMW_RD) ? ST_RMW_WR : ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_data_M <= '0;
      done_M      <= 1'b0;
      misalign_M  <= 1'b0;
      bus_err_M   <= 1'b0;
      cnt         <= '0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      // Request and pulse outputs are registered copies of the next state.
      mem_req    <= (next_state == ST_RD) || (next_state == ST_RMW_RD) ||
                    (next_state == ST_RMW_WR) || (next_state == ST_WR);
      mem_we     <= (next_state == ST_RMW_WR) || (next_state == ST_WR);
      done_M     <= (next_state == ST_DONE);
      bus_err_M  <= timeout_hit;
      misalign_M <= (state == ST_IDLE) && op_valid && op_mis;

      if (next_state != state) cnt <= '0;
      else if (in_req)         cnt <= cnt + CNT_W'(1);

      if (state == ST_IDLE && op_valid) begin
        off_q    <= ALU_result_M[1:0];
        size_q   <= Size_M;
        uns_q    <= Unsigned_M;
        wdata_q  <= Write_Data_M;
        mem_addr <= {ALU_result_M[ADDR_W-1:2], 2'b00};
        if (Mem_Write_M && Size_M == SZ_W) mem_wdata <= Write_Data_M;
      end

      if (state == ST_RMW_RD && mem_ack) mem_wdata <= merged;

      if (state == ST_RD && mem_ack) load_data_M <= load_ext;
      else if (timeout_hit)          load_data_M <= '0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu with a word-array reference model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Mem_Read_M = 1'b0, Mem_Write_M = 1'b0, Unsigned_M = 1'b0;
  logic [1:0]  Size_M = 2'b00;
  logic [31:0] ALU_result_M = '0, Write_Data_M = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] load_data_M;
  logic        done_M, stall_M, misalign_M, bus_err_M;

  mem_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M), .Size_M(Size_M),
    .Unsigned_M(Unsigned_M), .ALU_result_M(ALU_result_M), .Write_Data_M(Write_Data_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_data_M(load_data_M),
    .done_M(done_M), .stall_M(stall_M), .misalign_M(misalign_M), .bus_err_M(bus_err_M)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {kind, expected load_data_M}; kind 0 done, 1 misalign, 2 bus error
  logic [33:0] exp_q[$];
  logic [31:0] model_mem[16];
  logic [31:0] resp_mem[16];
  logic [31:0] last_load = '0;

  // memory responder controls
  bit          hold_ack = 1'b0;
  bit          reads_only = 1'b0;
  bit          zero_wait = 1'b0;
  int          wait_left = 0;
  int          req_cycles = 0;
  logic [31:0] exp_word_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // reference model: computes the architectural outcome of one op
  task automatic model_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, v, mask;
    int sh;
    bit mis;
    if (!rd && !wr) return;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    sh = 8 * int'(a[1:0]);
    w = model_mem[a[5:2]];
    if (mis) begin
      exp_q.push_back({2'd1, last_load});
    end else if (wr) begin
      if (sz == 2'd0)      mask = 32'hFF << sh;
      else if (sz == 2'd1) mask = 32'hFFFF << sh;
      else                 mask = 32'hFFFF_FFFF;
      model_mem[a[5:2]] = (w & ~mask) | ((wd << sh) & mask);
      exp_q.push_back({2'd0, last_load});
    end else begin
      if (sz == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (!un && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (!un && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      last_load = v;
      exp_q.push_back({2'd0, v});
    end
  endtask

  // driver: present op, hold it while stalled, return after the consuming edge
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input bit tmo,
                       input int exp_stall, input int exp_req, input string nm);
    int st, r0;
    if (tmo) begin
      exp_q.push_back({2'd2, 32'h0});
      last_load = '0;
    end else begin
      model_op(rd, wr, sz, un, a, wd);
    end
    @(negedge clk);
    Mem_Read_M = rd; Mem_Write_M = wr; Size_M = sz; Unsigned_M = un;
    ALU_result_M = a; Write_Data_M = wd;
    exp_word_addr = {a[31:2], 2'b00};
    #1;
    r0 = req_cycles;
    st = 0;
    while (stall_M) begin
      st++;
      @(negedge clk);
      #1;
      if (st > 100) begin
        n_checks++; n_errors++;
        $display("FAIL %s_stall_timeout: got stall after %0d cycles required release", nm, st);
        break;
      end
    end
    if (exp_stall >= 0) chk({nm, "_stall_cycles"}, 32'(st), 32'(exp_stall));
    if (exp_req >= 0)   chk({nm, "_req_cycles"}, 32'(req_cycles - r0), 32'(exp_req));
    @(posedge clk);
  endtask

  task automatic idle_op();
    @(negedge clk);
    Mem_Read_M = 1'b0; Mem_Write_M = 1'b0;
  endtask

  // memory responder: random wait states, spurious acks while no request
  initial begin
    bit allow;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        req_cycles++;
        allow = !hold_ack && !(reads_only && mem_we);
        if (allow && wait_left == 0) begin
          mem_ack = 1'b1;
          chk("mem_addr", mem_addr, exp_word_addr);
          if (mem_we) begin
            resp_mem[mem_addr[5:2]] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = resp_mem[mem_addr[5:2]];
          end
          wait_left = zero_wait ? 0 : int'($urandom_range(0, 3));
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          if (allow && wait_left > 0) wait_left--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // monitor: pops the scoreboard on every completion or misalign pulse
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && (done_M || misalign_M || bus_err_M)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_pulse: got done=%0b mis=%0b berr=%0b required none",
                   done_M, misalign_M, bus_err_M);
        end else begin
          e = exp_q.pop_front();
          if (e[33:32] == 2'd1) begin
            chk("misalign_pulse", {29'b0, misalign_M, done_M, bus_err_M}, 32'h4);
          end else begin
            chk("completion_pulse", {29'b0, misalign_M, done_M, bus_err_M},
                {29'b0, 1'b0, 1'b1, e[33:32] == 2'd2});
            chk("load_data", load_data_M, e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    n_errors++;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rq;
    int g;
    logic [1:0]  sz;
    logic [31:0] a;
    int r;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      resp_mem[i]  = model_mem[i];
    end
    model_mem[0] = 32'h8011_2233; resp_mem[0] = 32'h8011_2233;
    model_mem[1] = 32'h1122_3344; resp_mem[1] = 32'h1122_3344;
    model_mem[2] = 32'hDEAD_BEEF; resp_mem[2] = 32'hDEAD_BEEF;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {26'b0, mem_req, mem_we, done_M, misalign_M, bus_err_M, stall_M}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_load_data", load_data_M, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed, zero-wait memory
    zero_wait = 1'b1;
    do_op(1, 0, SZ_W, 0, 32'h8, 32'h0, 0, 2, 1, "lw");
    #1 chk("lw_value", load_data_M, 32'hDEAD_BEEF);
    do_op(1, 0, SZ_B, 0, 32'h3, 32'h0, 0, 2, 1, "lb");
    #1 chk("lb_value", load_data_M, 32'hFFFF_FF80);
    do_op(1, 0, SZ_B, 1, 32'h3, 32'h0, 0, 2, 1, "lbu");
    #1 chk("lbu_value", load_data_M, 32'h0000_0080);
    do_op(1, 0, SZ_H, 1, 32'h2, 32'h0, 0, 2, 1, "lhu");
    #1 chk("lhu_value", load_data_M, 32'h0000_8011);
    do_op(0, 1, SZ_B, 0, 32'h5, 32'hAB, 0, 3, 2, "sb");
    chk("sb_memory", resp_mem[1], 32'h1122_AB44);
    do_op(0, 1, SZ_W, 0, 32'hC, 32'hCAFE_F00D, 0, 2, 1, "sw");

    // misaligned: no request, no stall
    rq = req_cycles;
    do_op(1, 0, SZ_H, 0, 32'h1, 32'h0, 0, 0, -1, "lh_mis");
    do_op(1, 0, 2'b11, 0, 32'h0, 32'h0, 0, 0, -1, "sz11_mis");
    idle_op();
    repeat (3) @(negedge clk);
    chk("mis_no_req", 32'(req_cycles - rq), 32'h0);

    // ack timeout
    hold_ack = 1'b1;
    do_op(1, 0, SZ_W, 0, 32'h10, 32'h0, 1, 16, 15, "timeout");
    hold_ack = 1'b0;
    idle_op();
    repeat (2) @(negedge clk);

    // reset while waiting in the write phase of a read-modify-write
    reads_only = 1'b1;
    @(negedge clk);
    Mem_Write_M = 1'b1; Size_M = SZ_B; ALU_result_M = 32'h9; Write_Data_M = 32'h5A;
    exp_word_addr = 32'h8;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (!(mem_req && mem_we) && g < 30);
    chk("reached_rmw_wr", {31'b0, mem_req && mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {30'b0, mem_req, done_M}, 32'h0);
    Mem_Write_M = 1'b0;
    reads_only = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1, SZ_W, 0, 32'h0, 32'h1357_9BDF, 0, 2, 1, "sw_after_rst");

    // randomized traffic
    zero_wait = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_op();
      end else begin
        r = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | (i[0] & i[1]), sz,
              1'($urandom_range(0, 1)), a, $urandom, 0, -1, -1, "rand");
      end
    end

    idle_op();
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem_word_%0d", i), resp_mem[i], model_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
